// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice.
// Contents: station tag encodings, default depth, entry field widths and the
// per-entry storage record.
package reorder_buffer_pkg;

    localparam int unsigned TAG_W     = 4;
    localparam int unsigned RD_W      = 5;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_DEPTH = 8;

    // Reservation-station tags: ALU stations 1..3, load-store 4..7, 0 = none.
    typedef enum logic [TAG_W-1:0] {
        TAG_NONE = 4'd0,
        TAG_ADD1 = 4'd1,
        TAG_ADD2 = 4'd2,
        TAG_ADD3 = 4'd3,
        TAG_LSB0 = 4'd4,
        TAG_LSB1 = 4'd5,
        TAG_LSB2 = 4'd6,
        TAG_LSB3 = 4'd7
    } rs_tag_e;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic [TAG_W-1:0] tag;
        logic [RD_W-1:0]  rd;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  val;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of the reorder buffer's control, allocation, result and retirement
// signals. The slave modport is the buffer; master is the surrounding core.
//   control : rdy_in, flush_in
//   alloc   : alloc_valid/tag/rd/addr in, rob_full out
//   results : submit_* (ALU station), ls_submit_* (load-store buffer)
//   retire  : cdb_* broadcast, commit_* register-file write, unmatched_err
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic             rdy_in;
    logic             flush_in;
    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic [RD_W-1:0]  alloc_rd;
    logic [XLEN-1:0]  alloc_addr;
    logic             rob_full;
    logic             submit_valid;
    logic [TAG_W-1:0] submit_tag;
    logic [XLEN-1:0]  submit_val;
    logic             ls_submit_valid;
    logic [TAG_W-1:0] ls_submit_tag;
    logic [XLEN-1:0]  ls_submit_val;
    logic             cdb_active;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_val;
    logic [XLEN-1:0]  cdb_addr;
    logic             commit_valid;
    logic [RD_W-1:0]  commit_rd;
    logic [XLEN-1:0]  commit_val;
    logic             unmatched_err;

    modport master (
        output rdy_in, flush_in, alloc_valid, alloc_tag, alloc_rd, alloc_addr,
        output submit_valid, submit_tag, submit_val,
        output ls_submit_valid, ls_submit_tag, ls_submit_val,
        input  rob_full, cdb_active, cdb_tag, cdb_val, cdb_addr,
        input  commit_valid, commit_rd, commit_val, unmatched_err
    );

    modport slave (
        input  rdy_in, flush_in, alloc_valid, alloc_tag, alloc_rd, alloc_addr,
        input  submit_valid, submit_tag, submit_val,
        input  ls_submit_valid, ls_submit_tag, ls_submit_val,
        output rob_full, cdb_active, cdb_tag, cdb_val, cdb_addr,
        output commit_valid, commit_rd, commit_val, unmatched_err
    );

endinterface

// File: rtl/reorder_buffer_rob_tag_cam.sv
// rob_tag_cam: combinational DEPTH-way tag match for one result port.
//   i_valid   : result strobe
//   i_tag     : result tag (TAG_NONE never matches)
//   i_pending : per-entry busy && !done
//   i_tags    : per-entry stored tag
//   o_hit     : some pending entry matched
//   o_onehot  : matching entry (at most one by construction of tag reuse)
module rob_tag_cam
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH
) (
    input  logic                        i_valid,
    input  logic [TAG_W-1:0]            i_tag,
    input  logic [DEPTH-1:0]            i_pending,
    input  logic [DEPTH-1:0][TAG_W-1:0] i_tags,
    output logic                        o_hit,
    output logic [DEPTH-1:0]            o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_onehot[i] = i_valid && (i_tag != TAG_NONE) && i_pending[i] && (i_tags[i] == i_tag);
        end
    end

    assign o_hit = |o_onehot;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order completion buffer. Allocates entries in issue
// order, accepts out-of-order results from the ALU station and load-store
// buffer, and retires at most one completed head entry per cycle onto the
// CDB / register-file commit port.
//   clk_in : clock
//   rst_in : synchronous active-low reset
//   bus    : reorder_buffer_if.slave (control, alloc, results, retire)
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    reorder_buffer_if.slave  bus
);

    rob_entry_t       r_rob [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             r_cdb_active;
    logic [TAG_W-1:0] r_cdb_tag;
    logic [XLEN-1:0]  r_cdb_val;
    logic [XLEN-1:0]  r_cdb_addr;
    logic [RD_W-1:0]  r_commit_rd;
    logic             r_unmatched_err;

    logic [DEPTH-1:0]            w_pending;
    logic [DEPTH-1:0][TAG_W-1:0] w_tags;
    logic                        w_alu_hit;
    logic                        w_ls_hit;
    logic [DEPTH-1:0]            w_alu_oh;
    logic [DEPTH-1:0]            w_ls_oh;
    logic                        w_full;
    logic                        w_alloc;
    logic                        w_retire;
    logic                        w_miss;

    always_comb begin
        w_pending = '0;
        w_tags    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_pending[i] = r_rob[i].busy && !r_rob[i].done;
            w_tags[i]    = r_rob[i].tag;
        end
    end

    rob_tag_cam #(.DEPTH(DEPTH)) u_cam_alu (
        .i_valid   (bus.submit_valid),
        .i_tag     (bus.submit_tag),
        .i_pending (w_pending),
        .i_tags    (w_tags),
        .o_hit     (w_alu_hit),
        .o_onehot  (w_alu_oh)
    );

    rob_tag_cam #(.DEPTH(DEPTH)) u_cam_ls (
        .i_valid   (bus.ls_submit_valid),
        .i_tag     (bus.ls_submit_tag),
        .i_pending (w_pending),
        .i_tags    (w_tags),
        .o_hit     (w_ls_hit),
        .o_onehot  (w_ls_oh)
    );

    // Full is judged on the current count: a same-cycle retire does not free a slot.
    assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign w_alloc  = bus.alloc_valid && !w_full;
    assign w_retire = (r_count != '0) && r_rob[r_head].busy && r_rob[r_head].done;
    assign w_miss   = (bus.submit_valid && (bus.submit_tag != TAG_NONE) && !w_alu_hit) ||
                      (bus.ls_submit_valid && (bus.ls_submit_tag != TAG_NONE) && !w_ls_hit);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_cdb_active    <= 1'b0;
            r_cdb_tag       <= '0;
            r_cdb_val       <= '0;
            r_cdb_addr      <= '0;
            r_commit_rd     <= '0;
            r_unmatched_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rob[i] <= '0;
            end
        end else if (bus.rdy_in) begin
            if (bus.flush_in) begin
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_cdb_active <= 1'b0;
                r_cdb_tag    <= '0;
                r_cdb_val    <= '0;
                r_cdb_addr   <= '0;
                r_commit_rd  <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    r_rob[i] <= '0;
                end
            end else begin
                r_cdb_active <= w_retire;
                if (w_retire) begin
                    r_cdb_tag           <= r_rob[r_head].tag;
                    r_cdb_val           <= r_rob[r_head].val;
                    r_cdb_addr          <= r_rob[r_head].addr;
                    r_commit_rd         <= r_rob[r_head].rd;
                    r_rob[r_head].busy  <= 1'b0;
                    r_rob[r_head].done  <= 1'b0;
                    r_head              <= r_head + 1'b1;
                end

                // Matches only hit pending (not done) entries, so the retiring
                // head and the free tail slot are never touched here.
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (w_alu_oh[i]) begin
                        r_rob[i].done <= 1'b1;
                        r_rob[i].val  <= bus.submit_val;
                    end else if (w_ls_oh[i]) begin
                        r_rob[i].done <= 1'b1;
                        r_rob[i].val  <= bus.ls_submit_val;
                    end
                end

                if (w_alloc) begin
                    r_rob[r_tail].busy <= 1'b1;
                    r_rob[r_tail].done <= 1'b0;
                    r_rob[r_tail].tag  <= bus.alloc_tag;
                    r_rob[r_tail].rd   <= bus.alloc_rd;
                    r_rob[r_tail].addr <= bus.alloc_addr;
                    r_rob[r_tail].val  <= '0;
                    r_tail             <= r_tail + 1'b1;
                end

                if (w_alloc && !w_retire) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_alloc && w_retire) begin
                    r_count <= r_count - 1'b1;
                end

                if (w_miss) begin
                    r_unmatched_err <= 1'b1;
                end
            end
        end
    end

    assign bus.rob_full      = w_full;
    assign bus.cdb_active    = r_cdb_active;
    assign bus.cdb_tag       = r_cdb_tag;
    assign bus.cdb_val       = r_cdb_val;
    assign bus.cdb_addr      = r_cdb_addr;
    assign bus.commit_valid  = r_cdb_active;
    assign bus.commit_rd     = r_commit_rd;
    assign bus.commit_val    = r_cdb_val;
    assign bus.unmatched_err = r_unmatched_err;

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer. The reference model is a program-order queue
// of outstanding instructions; retirements it predicts go into a scoreboard
// queue that a negedge monitor drains whenever the DUT broadcasts.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic clk_in;
    logic rst_in;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    reorder_buffer_if bus();

    reorder_buffer #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] val;
        bit          done;
    } m_ent_t;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] val;
    } m_ret_t;

    m_ent_t mq[$];
    m_ret_t exp_q[$];
    m_ret_t e_pop;
    m_ret_t hold;
    bit     m_active;
    bit     m_err;
    bit     m_clr;
    bit     m_full;
    bit     m_edge_rdy;

    int unsigned n_pass;
    int unsigned n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic void model_submit(input logic v, input logic [3:0] t, input logic [31:0] d);
        if (!v || t == 4'd0) return;
        foreach (mq[i]) begin
            if (!mq[i].done && mq[i].tag == t) begin
                mq[i].done = 1'b1;
                mq[i].val  = d;
                return;
            end
        end
        m_err = 1'b1;
    endfunction

    // Reference model, evaluated on the same edge the DUT samples its inputs.
    always @(posedge clk_in) begin
        m_edge_rdy = rst_in && bus.rdy_in;
        if (!rst_in) begin
            mq.delete();
            exp_q.delete();
            m_active = 1'b0;
            m_err    = 1'b0;
            m_clr    = 1'b1;
        end else if (bus.rdy_in) begin
            if (bus.flush_in) begin
                mq.delete();
                exp_q.delete();
                m_active = 1'b0;
                m_clr    = 1'b1;
            end else begin
                m_full   = (mq.size() == DEPTH);
                m_active = 1'b0;
                if (mq.size() > 0 && mq[0].done) begin
                    exp_q.push_back('{mq[0].tag, mq[0].rd, mq[0].addr, mq[0].val});
                    void'(mq.pop_front());
                    m_active = 1'b1;
                end
                model_submit(bus.submit_valid, bus.submit_tag, bus.submit_val);
                model_submit(bus.ls_submit_valid, bus.ls_submit_tag, bus.ls_submit_val);
                if (bus.alloc_valid && !m_full)
                    mq.push_back('{bus.alloc_tag, bus.alloc_rd, bus.alloc_addr, 32'd0, 1'b0});
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a new broadcast.
    always @(negedge clk_in) begin
        if (m_clr) begin
            hold  = '{4'd0, 5'd0, 32'd0, 32'd0};
            m_clr = 1'b0;
        end
        if (bus.cdb_active === 1'b1 && m_edge_rdy) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_cdb: got tag %0h val %0h, expected no retirement (t=%0t)",
                         bus.cdb_tag, bus.cdb_val, $time);
            end else begin
                e_pop = exp_q.pop_front();
                hold  = e_pop;
            end
        end
        chk("cdb_active",    {31'd0, bus.cdb_active},    {31'd0, m_active});
        chk("commit_valid",  {31'd0, bus.commit_valid},  {31'd0, m_active});
        chk("rob_full",      {31'd0, bus.rob_full},      {31'd0, mq.size() == DEPTH});
        chk("unmatched_err", {31'd0, bus.unmatched_err}, {31'd0, m_err});
        chk("cdb_tag",       {28'd0, bus.cdb_tag},       {28'd0, hold.tag});
        chk("cdb_val",       bus.cdb_val,                hold.val);
        chk("commit_val",    bus.commit_val,             hold.val);
        chk("cdb_addr",      bus.cdb_addr,               hold.addr);
        chk("commit_rd",     {27'd0, bus.commit_rd},     {27'd0, hold.rd});
    end

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic idle();
        bus.rdy_in          = 1'b1;
        bus.flush_in        = 1'b0;
        bus.alloc_valid     = 1'b0;
        bus.alloc_tag       = '0;
        bus.alloc_rd        = '0;
        bus.alloc_addr      = '0;
        bus.submit_valid    = 1'b0;
        bus.submit_tag      = '0;
        bus.submit_val      = '0;
        bus.ls_submit_valid = 1'b0;
        bus.ls_submit_tag   = '0;
        bus.ls_submit_val   = '0;
    endtask

    task automatic do_alloc(input logic [3:0] t, input logic [4:0] rd, input logic [31:0] a);
        bus.alloc_valid = 1'b1;
        bus.alloc_tag   = t;
        bus.alloc_rd    = rd;
        bus.alloc_addr  = a;
        step();
        idle();
    endtask

    task automatic do_sub(input logic [3:0] t, input logic [31:0] v);
        bus.submit_valid = 1'b1;
        bus.submit_tag   = t;
        bus.submit_val   = v;
        step();
        idle();
    endtask

    task automatic idle_n(input int n);
        idle();
        repeat (n) step();
    endtask

    // Tags are drawn from the whole 4-bit space so a full buffer can hold distinct tags.
    function automatic logic [3:0] free_tag();
        int   s;
        logic [3:0] t;
        bit   used;
        s = $urandom_range(0, 14);
        for (int k = 0; k < 15; k++) begin
            t = 4'((s + k) % 15 + 1);
            used = 1'b0;
            foreach (mq[i]) if (!mq[i].done && mq[i].tag == t) used = 1'b1;
            if (!used) return t;
        end
        return 4'd0;
    endfunction

    task automatic random_submits(input int pct);
        int idx[$];
        int k;
        foreach (mq[i]) if (!mq[i].done) idx.push_back(i);
        if (idx.size() > 0 && $urandom_range(0, 99) < pct) begin
            k = $urandom_range(0, idx.size() - 1);
            bus.submit_valid = 1'b1;
            bus.submit_tag   = mq[idx[k]].tag;
            bus.submit_val   = $urandom;
            idx.delete(k);
        end
        if (idx.size() > 0 && $urandom_range(0, 99) < pct) begin
            k = $urandom_range(0, idx.size() - 1);
            bus.ls_submit_valid = 1'b1;
            bus.ls_submit_tag   = mq[idx[k]].tag;
            bus.ls_submit_val   = $urandom;
        end
    endtask

    initial begin
        logic [3:0] t;
        n_pass  = 0;
        n_total = 0;
        hold    = '{4'd0, 5'd0, 32'd0, 32'd0};

        // Reset with an allocation request held high.
        rst_in = 1'b0;
        idle();
        bus.alloc_valid = 1'b1;
        bus.alloc_tag   = 4'd1;
        repeat (2) step();
        idle();
        rst_in = 1'b1;
        step();

        // Out-of-order completion.
        do_alloc(4'd1, 5'd5, 32'h100);
        do_alloc(4'd2, 5'd6, 32'h104);
        do_alloc(4'd3, 5'd7, 32'h108);
        do_sub(4'd3, 32'h33);
        do_sub(4'd1, 32'h11);
        do_sub(4'd2, 32'h22);
        idle_n(4);

        // Dual submit, entries in order 4, 2.
        do_alloc(4'd4, 5'd8, 32'h200);
        do_alloc(4'd2, 5'd9, 32'h204);
        bus.submit_valid    = 1'b1;
        bus.submit_tag      = 4'd2;
        bus.submit_val      = 32'hA;
        bus.ls_submit_valid = 1'b1;
        bus.ls_submit_tag   = 4'd4;
        bus.ls_submit_val   = 32'hB;
        step();
        idle_n(4);

        // Fill, drop when full, retire head, allocate into the wrapped slot.
        for (int i = 1; i <= 8; i++) do_alloc(4'(i), 5'(i), 32'h300 + 32'(4 * i));
        do_alloc(4'd9, 5'd9, 32'h3F0);
        do_sub(4'd1, 32'h1001);
        idle_n(1);
        do_alloc(4'd10, 5'd10, 32'h400);
        for (int i = 2; i <= 8; i++) do_sub(4'(i), 32'h1000 + 32'(i));
        do_sub(4'd10, 32'h100A);
        idle_n(4);

        // 20 alloc/retire pairs, pipelined one per cycle.
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                bus.alloc_valid = 1'b1;
                bus.alloc_tag   = 4'(i % 15 + 1);
                bus.alloc_rd    = 5'(i);
                bus.alloc_addr  = 32'h500 + 32'(4 * i);
            end
            if (i > 0) begin
                bus.submit_valid = 1'b1;
                bus.submit_tag   = 4'((i - 1) % 15 + 1);
                bus.submit_val   = 32'h5000 + 32'(i);
            end
            step();
            idle();
        end
        idle_n(4);

        // Flush with four pending entries, the head ready to retire.
        for (int i = 1; i <= 4; i++) do_alloc(4'(i), 5'(i), 32'h600 + 32'(4 * i));
        do_sub(4'd1, 32'h61);
        bus.flush_in = 1'b1;
        step();
        idle_n(3);

        // Pause across a pending retirement.
        do_alloc(4'd5, 5'd3, 32'h700);
        do_sub(4'd5, 32'h77);
        bus.rdy_in = 1'b0;
        repeat (3) step();
        idle_n(3);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            idle();
            bus.rdy_in   = ($urandom_range(0, 9) != 0);
            bus.flush_in = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 9) < 6) begin
                t = free_tag();
                if (t != 4'd0) begin
                    bus.alloc_valid = 1'b1;
                    bus.alloc_tag   = t;
                    bus.alloc_rd    = 5'($urandom_range(0, 31));
                    bus.alloc_addr  = $urandom;
                end
            end
            random_submits(40);
            step();
        end

        // Drain everything outstanding.
        for (int c = 0; c < 40; c++) begin
            idle();
            random_submits(100);
            step();
        end
        idle_n(3);
        chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);

        // Unmatched submit is sticky until reset.
        rst_in = 1'b0;
        idle_n(1);
        rst_in = 1'b1;
        idle_n(1);
        do_sub(4'd3, 32'h3);
        idle_n(2);
        do_alloc(4'd3, 5'd1, 32'h800);
        do_sub(4'd3, 32'h83);
        idle_n(3);
        rst_in = 1'b0;
        idle_n(1);
        rst_in = 1'b1;
        idle_n(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order completion buffer on the far side of the reservation-station result interface.
- Receives issue-order allocations from the instruction queue, and out-of-order results (tag/value) from the ALU reservation station and the load-store buffer.
- Retires entries strictly in program order, one per cycle.
- On each retirement, drives the common data bus (cdb_*) consumed by the stations, and the register-file write/commit port.

Parameters:
DEPTH, 8, number of entries (power of two, 2..16)
PTR_W, 3, log2(DEPTH)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous reset, active-low
rdy_in  input  1  global enable; 0 = pause, all state and outputs hold
flush_in  input  1  mispredict flush; clears all entries
alloc_valid  input  1  allocate one entry this cycle
alloc_tag  input  4  station tag the instruction was issued to (RS 1..3, LSB 4..7; 0 = None, never allocated)
alloc_rd  input  5  destination register (0 for branch/store)
alloc_addr  input  32  instruction pc
rob_full  output  1  combinational: count == DEPTH
submit_valid  input  1  ALU station result valid
submit_tag  input  4  ALU station result tag
submit_val  input  32  ALU station result value
ls_submit_valid  input  1  load-store result valid
ls_submit_tag  input  4  load-store result tag
ls_submit_val  input  32  load-store result value
cdb_active  output  1  broadcast valid (registered)
cdb_tag  output  4  broadcast tag
cdb_val  output  32  broadcast value
cdb_addr  output  32  pc of retired instruction
commit_valid  output  1  regfile write strobe (registered, equals cdb_active)
commit_rd  output  5  regfile write index
commit_val  output  32  regfile write data
unmatched_err  output  1  sticky: a submit found no pending entry

Behaviour:
- Storage: circular buffer with head, tail (PTR_W bits) and count (PTR_W+1 bits).
- Per-entry fields: busy, done, tag, rd, addr, val.
- Reset (rst_in==0 at edge):
  - head = tail = count = 0; all busy/done = 0.
  - All outputs 0; unmatched_err = 0.
  - Reset has priority over rdy_in and flush_in, and aborts any in-flight entries.
- rdy_in==0: no state change; registered outputs hold their values.
- Priority when rdy_in==1: flush_in > (allocate, submit, retire), which occur concurrently.
- Flush:
  - All entries cleared; head = tail = count = 0.
  - Registered outputs forced to 0 next cycle.
  - Same-cycle alloc and submits are ignored.
- Allocate:
  - If alloc_valid && !rob_full: entry[tail] = {busy=1, done=0, tag, rd, addr}; tail wraps modulo DEPTH.
  - If full: the request is dropped. The issue side must stall on rob_full.
  - rob_full is computed from the current count, so a same-cycle retirement does not free a slot for this cycle's allocation.
- Submit:
  - Each valid submit is matched against the unique entry with busy && !done && tag equal.
  - The stations free their tag on submit, so at most one match exists.
  - On match: done=1 and val=value.
  - ALU and LS submits in the same cycle carry disjoint tags; both are accepted.
  - A submit with tag 0 is ignored.
  - No match: ignored and unmatched_err set.
  - Submits are always accepted; there is no backpressure.
- Retire:
  - If count>0 && entry[head].busy && entry[head].done: clear the entry, head advances (wraps).
  - Next cycle: cdb_active=commit_valid=1, cdb_tag=tag, cdb_val=commit_val=val, cdb_addr=addr, commit_rd=rd.
  - Otherwise cdb_active=commit_valid=0; the data outputs hold their previous values.
- count update: +1 on accepted alloc, -1 on retire; both in the same cycle leaves it unchanged.
- Latency:
  - Submit accepted at edge E leads to retirement at edge E+1 when the entry is at head, so cdb_active is visible in the cycle after E+1.
  - An entry allocated at edge A can retire no earlier than edge A+2.
- Throughput: at most one retirement per cycle.
- rd==0 entries still retire and broadcast (branches/stores wake waiters); the regfile ignores x0.

Decomposition:
- Shared macros.v: tag encodings (None=4'd0, Add1..Add3, LSB tags), ROB depth default, entry field widths.
- One sub-module, rob_tag_cam: combinational DEPTH-way match of one tag against busy&&!done entries, returning hit plus one-hot index. It is instantiated twice, once per submit port.

Test Plan:
1. Reset: rst_in=0 for 2 cycles with alloc_valid=1 -> count=0, rob_full=0, cdb_active=0, unmatched_err=0.
2. Out-of-order completion:
   - Stimulus: alloc tags 1,2,3 (rd 5,6,7); submit tag 3 val 0x33, then tag 1 val 0x11, then tag 2 val 0x22.
   - Required: cdb sequence tag1/0x11/rd5, tag2/0x22/rd6, tag3/0x33/rd7, in consecutive cycles once tag 2 is done.
3. Dual submit: ALU tag 2 val 0xA and LS tag 4 val 0xB in the same cycle, entries at head in order 4, 2 -> cdb tag4/0xB then tag2/0xA on back-to-back cycles.
4. Full and wrap:
   - Allocate 8 entries -> rob_full=1; a 9th alloc is dropped.
   - Complete head -> retire; alloc the next cycle succeeds with tail wrapped to 0.
   - 20 alloc/retire pairs keep order intact.
5. Flush and pause:
   - Stimulus: 4 pending entries, flush_in=1 -> count=0, cdb_active=0 next cycle.
   - Stimulus: rdy_in=0 during a pending retire -> nothing changes until rdy_in=1.
6. Unmatched submit: submit tag 3 with no pending entry -> unmatched_err=1, stays 1 until reset; no cdb activity.
